// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq
//   Sequential hazard controller for the RV32 pipeline. It sits beside the
//   decode stage and provides:
//   - Independent forwarding for rs1 and rs2 from the E stage and the M/WB
//     stage. The E stage has priority, and x0 never matches.
//   - Multi-cycle load-use stalls (LOAD_LAT), UART byte-transfer stalls and
//     multi-cycle flushes (FLUSH_CYCLES), all held by an explicit FSM.
//   - A stall watchdog that pulses timeout_o after STALL_MAX consecutive
//     stall cycles.
//   Optional feature: define HAZARD_STATS_EN to build the saturating
//   stall and flush event counters. When it is undefined, both counter
//   outputs are tied to zero.
//   All outputs read 0 while rst is low, and in the first cycle after
//   rst is released.
module hazard_ctrl_seq #(
  parameter int LOAD_LAT     = 1,   // 1..7
  parameter int FLUSH_CYCLES = 1,   // 1..3
  parameter int STALL_MAX    = 15   // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir_d,
  input  logic [31:0] ir_e,
  input  logic [31:0] ir_m,
  input  logic        reg_wr_e,
  input  logic        reg_wr_m,
  input  logic [1:0]  wb_sel_e,
  input  logic        br_taken,
  input  logic        t_byte_i,
  output logic [1:0]  for_a,
  output logic [1:0]  for_b,
  output logic        stall,
  output logic        flush,
  output logic        timeout_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_UART_WAIT = 2'd2,
    S_FLUSH     = 2'd3
  } state_t;

  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_E    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT);
  localparam logic [1:0] FL_INIT  = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LAST  = 8'(STALL_MAX - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_lat_cnt;
  logic [2:0]  w_lat_nxt;
  logic [1:0]  r_fl_cnt;
  logic [1:0]  w_fl_nxt;
  logic [7:0]  r_wd_cnt;
  logic        r_active;

  logic        w_live;
  logic        w_flush_entry;
  logic [4:0]  w_rs1_d;
  logic [4:0]  w_rs2_d;
  logic [4:0]  w_rd_e;
  logic [4:0]  w_rd_m;
  logic        w_e_fwd_ok;
  logic        w_m_fwd_ok;
  logic        w_load_e;
  logic        w_load_use;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // Only the register fields of the instruction words are used here.
  logic        w_unused;
  assign w_unused = ^{ir_d[31:25], ir_d[14:0], ir_e[31:12], ir_e[6:0],
                      ir_m[31:12], ir_m[6:0]};

  assign w_rs1_d = ir_d[19:15];
  assign w_rs2_d = ir_d[24:20];
  assign w_rd_e  = ir_e[11:7];
  assign w_rd_m  = ir_m[11:7];

  // The controller is live only out of reset and after one settling cycle.
  assign w_live = rst & r_active;

  // A load result is not available in E, so it can never be forwarded from E.
  // Requiring rd != 0 makes x0 unable to match any source operand.
  assign w_load_e   = reg_wr_e & (wb_sel_e == WB_LOAD);
  assign w_e_fwd_ok = reg_wr_e & (wb_sel_e != WB_LOAD) & (w_rd_e != 5'd0);
  assign w_m_fwd_ok = reg_wr_m & (w_rd_m != 5'd0);
  assign w_load_use = w_load_e & (w_rd_e != 5'd0) &
                      ((w_rd_e == w_rs1_d) | (w_rd_e == w_rs2_d));

  // Select the forward source for each operand. E outranks M/WB.
  always_comb begin
    w_fwd_a = FWD_NONE;
    w_fwd_b = FWD_NONE;
    if (w_e_fwd_ok && (w_rd_e == w_rs1_d))      w_fwd_a = FWD_E;
    else if (w_m_fwd_ok && (w_rd_m == w_rs1_d)) w_fwd_a = FWD_M;
    if (w_e_fwd_ok && (w_rd_e == w_rs2_d))      w_fwd_b = FWD_E;
    else if (w_m_fwd_ok && (w_rd_m == w_rs2_d)) w_fwd_b = FWD_M;
  end

  // Next-state and Mealy outputs of the hazard FSM.
  // Branch beats load-use, and load-use beats a UART transfer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat_cnt;
    w_fl_nxt      = r_fl_cnt;
    w_flush_entry = 1'b0;
    for_a         = FWD_NONE;
    for_b         = FWD_NONE;
    stall         = 1'b0;
    flush         = 1'b0;
    if (w_live) begin
      unique case (r_state)
        S_RUN: begin
          for_a = w_fwd_a;
          for_b = w_fwd_b;
          if (br_taken) begin
            // The taken branch squashes the dependent D instruction.
            flush         = 1'b1;
            w_flush_entry = 1'b1;
            w_fl_nxt      = FL_INIT;
            w_state_nxt   = (FL_INIT != 2'd0) ? S_FLUSH : S_RUN;
          end else if (w_load_use) begin
            stall       = 1'b1;
            w_lat_nxt   = LAT_INIT;
            w_state_nxt = S_LOAD_WAIT;
          end else if (t_byte_i) begin
            stall       = 1'b1;
            w_state_nxt = S_UART_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          // The E stage holds a bubble here, so its inputs are not re-examined.
          stall     = 1'b1;
          w_lat_nxt = r_lat_cnt - 3'd1;
          if (r_lat_cnt <= 3'd1) begin
            w_lat_nxt   = 3'd0;
            w_state_nxt = S_RUN;
          end
        end
        S_UART_WAIT: begin
          if (t_byte_i) stall = 1'b1;
          else          w_state_nxt = S_RUN;
        end
        S_FLUSH: begin
          if (r_fl_cnt != 2'd0) begin
            flush    = 1'b1;
            w_fl_nxt = r_fl_cnt - 2'd1;
          end
          if (r_fl_cnt <= 2'd1) w_state_nxt = S_RUN;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // FSM state, latency and flush counters. Reset aborts any wait at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge regardless of statement order.
    if (!rst) begin
      r_state   <= S_RUN;
      r_lat_cnt <= 3'd0;
      r_fl_cnt  <= 2'd0;
      r_active  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_nxt;
      r_fl_cnt  <= w_fl_nxt;
      r_active  <= 1'b1;
    end
  end

  // Stall watchdog: count consecutive stall cycles and wrap at expiry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd_cnt <= 8'd0;
    end else if (!stall) begin
      r_wd_cnt <= 8'd0;
    end else if (r_wd_cnt == WD_LAST) begin
      r_wd_cnt <= 8'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 8'd1;
    end
  end

  // The pulse lands on the stall cycle that brings the count to STALL_MAX.
  assign timeout_o = stall & (r_wd_cnt == WD_LAST);

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  // Saturating totals of stall cycles and RUN-to-flush entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0;
      r_flush_cnt <= 16'h0;
    end else begin
      if (stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_entry && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_flush_entry;
  assign stall_cnt_o    = 16'h0;
  assign flush_cnt_o    = 16'h0;
`endif

endmodule
